// File: rtl/spd_avg_mon.sv
// rtl/spd_avg_mon.sv - windowed wheel-speed average, trend and imbalance monitor
module spd_avg_mon #(
  parameter int SPD_W     = 12,
  parameter int LOG2_N    = 10,
  parameter int IMBAL_TOL = 10,
  parameter int TREND_TOL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    vld,
  input  logic signed [SPD_W-1:0] lft_spd,
  input  logic signed [SPD_W-1:0] rght_spd,
  output logic signed [SPD_W-1:0] avg_lft,
  output logic signed [SPD_W-1:0] avg_rght,
  output logic                    avg_vld,
  output logic                    trend_vld,
  output logic                    trend_up,
  output logic                    trend_dn,
  output logic                    imbal,
  output logic [15:0]             imbal_cnt
);

  localparam int AW = SPD_W + LOG2_N;
  localparam logic signed [SPD_W:0] TTOL    = (SPD_W+1)'(TREND_TOL);
  localparam logic        [SPD_W:0] IMB_TOL = (SPD_W+1)'(IMBAL_TOL);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic signed [AW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [LOG2_N-1:0]        cnt_q, cnt_d;
  logic signed [SPD_W-1:0]  avg_l_q, avg_l_d, avg_r_q, avg_r_d;
  logic                     avg_vld_q, avg_vld_d;
  logic                     trend_vld_q, trend_vld_d;
  logic                     up_q, up_d, dn_q, dn_d;
  logic                     have_prev_q, have_prev_d;
  logic                     imbal_q, imbal_d;
  logic [15:0]              imbal_cnt_q, imbal_cnt_d;

  logic                     accept;
  logic signed [AW-1:0]     sum_l, sum_r, shl_l, shl_r;
  logic signed [SPD_W-1:0]  new_l, new_r;
  logic signed [SPD_W:0]    dl, dr, sdiff;
  logic        [SPD_W:0]    sabs;
  logic                     imb_hit;

  always_comb begin
    accept  = (state_q == ACCUM) && en && vld;
    sum_l   = acc_l_q + {{LOG2_N{lft_spd[SPD_W-1]}}, lft_spd};
    sum_r   = acc_r_q + {{LOG2_N{rght_spd[SPD_W-1]}}, rght_spd};
    shl_l   = sum_l >>> LOG2_N;
    shl_r   = sum_r >>> LOG2_N;
    new_l   = shl_l[SPD_W-1:0];
    new_r   = shl_r[SPD_W-1:0];
    // Trend compares against the currently published averages, i.e. the previous window.
    dl      = {new_l[SPD_W-1], new_l} - {avg_l_q[SPD_W-1], avg_l_q};
    dr      = {new_r[SPD_W-1], new_r} - {avg_r_q[SPD_W-1], avg_r_q};
    sdiff   = {lft_spd[SPD_W-1], lft_spd} - {rght_spd[SPD_W-1], rght_spd};
    sabs    = sdiff[SPD_W] ? -sdiff : sdiff;
    imb_hit = accept && (sabs > IMB_TOL);

    state_d     = en ? ACCUM : IDLE;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    cnt_d       = cnt_q;
    avg_l_d     = avg_l_q;
    avg_r_d     = avg_r_q;
    avg_vld_d   = 1'b0;
    trend_vld_d = trend_vld_q;
    up_d        = up_q;
    dn_d        = dn_q;
    have_prev_d = have_prev_q;
    imbal_d     = imbal_q;
    imbal_cnt_d = imbal_cnt_q;

    if (!en) begin
      acc_l_d     = '0;
      acc_r_d     = '0;
      cnt_d       = '0;
      trend_vld_d = 1'b0;
      have_prev_d = 1'b0;
    end else if (accept) begin
      if (&cnt_q) begin
        acc_l_d     = '0;
        acc_r_d     = '0;
        cnt_d       = '0;
        avg_l_d     = new_l;
        avg_r_d     = new_r;
        avg_vld_d   = 1'b1;
        trend_vld_d = have_prev_q;
        up_d        = have_prev_q && (dl > TTOL) && (dr > TTOL);
        dn_d        = have_prev_q && (dl < -TTOL) && (dr < -TTOL);
        have_prev_d = 1'b1;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        cnt_d   = cnt_q + LOG2_N'(1);
      end
    end

    if (clr) begin
      imbal_d     = 1'b0;
      imbal_cnt_d = '0;
    end else if (imb_hit) begin
      imbal_d = 1'b1;
      if (imbal_cnt_q != 16'hFFFF) imbal_cnt_d = imbal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      cnt_q       <= '0;
      avg_l_q     <= '0;
      avg_r_q     <= '0;
      avg_vld_q   <= 1'b0;
      trend_vld_q <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      have_prev_q <= 1'b0;
      imbal_q     <= 1'b0;
      imbal_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      cnt_q       <= cnt_d;
      avg_l_q     <= avg_l_d;
      avg_r_q     <= avg_r_d;
      avg_vld_q   <= avg_vld_d;
      trend_vld_q <= trend_vld_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      have_prev_q <= have_prev_d;
      imbal_q     <= imbal_d;
      imbal_cnt_q <= imbal_cnt_d;
    end
  end

  assign avg_lft   = avg_l_q;
  assign avg_rght  = avg_r_q;
  assign avg_vld   = avg_vld_q;
  assign trend_vld = trend_vld_q;
  assign trend_up  = up_q;
  assign trend_dn  = dn_q;
  assign imbal     = imbal_q;
  assign imbal_cnt = imbal_cnt_q;

endmodule

// File: tb/tb_spd_avg_mon.sv
// tb/tb_spd_avg_mon.sv - scoreboard bench for spd_avg_mon with a 4-sample window
module tb_spd_avg_mon;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic vld = 1'b0;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic signed [11:0] avg_lft, avg_rght;
  logic avg_vld, trend_vld, trend_up, trend_dn, imbal;
  logic [15:0] imbal_cnt;

  typedef struct packed {
    logic signed [11:0] l;
    logic signed [11:0] r;
    logic tv;
    logic up;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  spd_avg_mon #(.SPD_W(12), .LOG2_N(2), .IMBAL_TOL(10), .TREND_TOL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .vld(vld),
    .lft_spd(lft_spd), .rght_spd(rght_spd),
    .avg_lft(avg_lft), .avg_rght(avg_rght), .avg_vld(avg_vld),
    .trend_vld(trend_vld), .trend_up(trend_up), .trend_dn(trend_dn),
    .imbal(imbal), .imbal_cnt(imbal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_avg(input int l, input int r, input bit tv, input bit up, input bit dn);
    exp_t e;
    e.l = 12'(l);
    e.r = 12'(r);
    e.tv = tv;
    e.up = up;
    e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic send(input int l, input int r);
    vld = 1'b1;
    lft_spd = 12'(l);
    rght_spd = 12'(r);
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  // Monitor: every avg_vld pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (avg_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_avg_vld: got avg_lft=%0d avg_rght=%0d, expected no pulse", avg_lft, avg_rght);
        end else begin
          e = exp_q.pop_front();
          check("avg_lft", int'(avg_lft), int'(e.l));
          check("avg_rght", int'(avg_rght), int'(e.r));
          check("trend_vld", int'(trend_vld), int'(e.tv));
          check("trend_up", int'(trend_up), int'(e.up));
          check("trend_dn", int'(trend_dn), int'(e.dn));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_avg_lft", int'(avg_lft), 0);
    check("rst_avg_rght", int'(avg_rght), 0);
    check("rst_avg_vld", int'(avg_vld), 0);
    check("rst_trend_vld", int'(trend_vld), 0);
    check("rst_trend_up", int'(trend_up), 0);
    check("rst_trend_dn", int'(trend_dn), 0);
    check("rst_imbal", int'(imbal), 0);
    check("rst_imbal_cnt", int'(imbal_cnt), 0);
    rst = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;

    expect_avg(103, 103, 0, 0, 0);
    send(100, 100); send(102, 102); send(104, 104); send(106, 106);
    expect_avg(120, 120, 1, 1, 0);
    for (int i = 0; i < 4; i++) send(120, 120);
    expect_avg(118, 118, 1, 0, 0);
    for (int i = 0; i < 4; i++) send(118, 118);
    expect_avg(50, 50, 1, 0, 1);
    for (int i = 0; i < 4; i++) send(50, 50);
    expect_avg(-1, -1, 1, 0, 1);
    send(-1, -1); send(-1, -1); send(-1, -1); send(0, 0);

    // Three windows with vld every cycle.
    expect_avg(10, 10, 1, 1, 0);
    expect_avg(20, 20, 1, 1, 0);
    expect_avg(30, 30, 1, 1, 0);
    for (int w = 1; w <= 3; w++)
      for (int i = 0; i < 4; i++) send(10 * w, 10 * w);

    // Imbalance; these four samples also form a window: 589>>>2=147, 679>>>2=169.
    expect_avg(147, 169, 1, 1, 0);
    send(200, 189);
    check("imbal_after_1", int'(imbal), 1);
    check("imbal_cnt_after_1", int'(imbal_cnt), 1);
    send(189, 200);
    check("imbal_cnt_after_2", int'(imbal_cnt), 2);
    send(200, 190);
    check("imbal_cnt_tol_edge", int'(imbal_cnt), 2);
    clr = 1'b1;
    send(0, 100);
    clr = 1'b0;
    check("imbal_clr", int'(imbal), 0);
    check("imbal_cnt_clr", int'(imbal_cnt), 0);

    // Abort after 3 samples; vld on the en-rise cycle must be ignored.
    for (int i = 0; i < 3; i++) send(1, 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    send(1000, 1000);
    expect_avg(40, 40, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(40, 40);

    // en drops on the 4th vld: no pulse may appear.
    for (int i = 0; i < 3; i++) send(5, 5);
    en = 1'b0;
    send(5, 5);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-window.
    send(7, 7);
    send(100, 0);
    check("imbal_pre_rst", int'(imbal_cnt), 1);
    rst = 1'b1;
    #1;
    check("midrst_avg_lft", int'(avg_lft), 0);
    check("midrst_avg_rght", int'(avg_rght), 0);
    check("midrst_imbal", int'(imbal), 0);
    check("midrst_imbal_cnt", int'(imbal_cnt), 0);
    check("midrst_trend_vld", int'(trend_vld), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_avg(60, 60, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(60, 60);

    // Saturation of imbal_cnt; each window of (200,0) is mixed vs the previous.
    for (int i = 0; i < 65537; i++) begin
      if ((i % 4 == 0) && (i + 3 < 65537)) expect_avg(200, 0, 1, 0, 0);
      send(200, 0);
      if (i == 65533) check("imbal_cnt_fffe", int'(imbal_cnt), 32'hFFFE);
    end
    check("imbal_cnt_sat", int'(imbal_cnt), 32'hFFFF);
    check("imbal_sat_flag", int'(imbal), 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spd_avg_mon.md
# spd_avg_mon

Windowed speed monitor that consumes the left/right wheel speed commands produced by the balance controller on each control update. Accumulates a power-of-two window of samples per side, publishes the window averages, classifies the trend against the previous window, and tracks left/right imbalance. Sits directly downstream of the balance controller. Its outputs feed status/telemetry logic and give verification a hardware-side observation point.

## Interface
- SPD_W, 12: width of signed speed inputs
- LOG2_N, 10: log2 of window length (N = 1024 samples); legal 1..12
- IMBAL_TOL, 10: max allowed |lft-rght| per sample before it counts as imbalanced
- TREND_TOL, 4: dead-band for trend classification

- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  monitor enable; low aborts current window
- clr  in  1  synchronous clear of imbalance count/flag
- vld  in  1  one-cycle strobe: lft_spd/rght_spd hold a new sample
- lft_spd  in  SPD_W  signed left speed
- rght_spd  in  SPD_W  signed right speed
- avg_lft  out  SPD_W  signed left window average
- avg_rght  out  SPD_W  signed right window average
- avg_vld  out  1  one-cycle pulse: new averages/trend valid
- trend_vld  out  1  level; trend_up/trend_dn meaningful (a previous window exists)
- trend_up  out  1  both averages rose by more than TREND_TOL vs previous window
- trend_dn  out  1  both averages fell by more than TREND_TOL vs previous window
- imbal  out  1  sticky: some sample exceeded IMBAL_TOL
- imbal_cnt  out  16  saturating count of imbalanced samples

## Operation
- States: IDLE (en=0) and ACCUM (en=1). IDLE->ACCUM when en=1; ACCUM->IDLE when en=0.
- Leaving ACCUM clears accumulators and sample counter. avg_lft/avg_rght hold their values. trend_vld clears.
- In ACCUM, each cycle with vld=1:
  - acc_x += sign-extended sample. Accumulators are SPD_W+LOG2_N bits signed, so overflow is impossible.
  - cnt increments.
- On the sample where cnt == N-1:
  - avg_x <= (acc_x + sample) >>> LOG2_N. Arithmetic shift, rounding toward -inf (e.g. sum -3 over N=4 gives -1).
  - acc and cnt reset to 0 in the same cycle, so no sample is lost between windows.
  - prev_x <= old avg_x.
- Trend is computed from the new averages vs the previous averages:
  - up = (new_l - prev_l > TREND_TOL) && (new_r - prev_r > TREND_TOL)
  - dn = same with < -TREND_TOL
  - up and dn are never both 1. Mixed or within-dead-band gives both 0.
  - Differences are computed at SPD_W+1 bits.
- The first completed window after reset or after re-enable sets trend_vld=0 and up/dn=0. Every later window sets trend_vld=1.
- Imbalance is evaluated on every accepted sample whenever en=1, independent of window position:
  - |lft-rght| is computed at SPD_W+1 bits; differences of either sign count.
  - A sample counts when |lft-rght| > IMBAL_TOL. It sets imbal and increments imbal_cnt, which saturates at 16'hFFFF.
- clr=1 zeroes imbal and imbal_cnt. clr wins over a simultaneous imbalanced sample.
- vld while en=0 is ignored entirely.

## Timing
- Reset values: all outputs 0; state IDLE; accumulators, cnt, prev registers 0.
- Averages: avg_vld pulses exactly one cycle, the cycle after the Nth accepted vld. avg_lft/avg_rght/trend_* update in that same cycle.
- Throughput: vld may be asserted every cycle; a full window takes N vld cycles.
- Imbalance: imbal/imbal_cnt update one cycle after the offending vld.
- en falling on the same cycle as the Nth vld: abort wins; no avg_vld is produced.
- en rising: the first vld is accepted the cycle en is seen high (state ACCUM registered) or later. A vld in the same cycle en rises is ignored.
- Reset asserted mid-window: everything returns to reset values immediately (asynchronous). The first window after release has trend_vld=0.

## Test plan
- LOG2_N=2, en=1, feed (100,100),(102,102),(104,104),(106,106) -> one cycle after the 4th vld: avg_vld=1, avg_lft=avg_rght=103, trend_vld=0.
- Continue with four samples of (120,120) -> avg=120, trend_vld=1, trend_up=1, trend_dn=0. Then four of (118,118) -> trend_up=trend_dn=0 (dead-band). Then four of (50,50) -> trend_dn=1.
- LOG2_N=2, samples (-1,-1),(-1,-1),(-1,-1),(0,0) -> avg=-1 (floor). Back-to-back vld every cycle across 3 windows -> exactly 3 avg_vld pulses, no dropped samples.
- Samples (200,189) and then (189,200) -> imbal=1, imbal_cnt=2. Sample (200,190) -> no count. Assert clr together with an imbalanced sample -> imbal=0, imbal_cnt=0.
- Drop en after 3 of 4 samples, re-raise en, feed 4 samples of (40,40) -> avg=40 with trend_vld=0. Preload imbal_cnt near 16'hFFFF -> it saturates.
- Assert rst mid-window -> all outputs 0 immediately. Assert en low on the 4th vld -> no avg_vld.
